// File: rtl/board_scanner.sv
// Sweeps the 10x10 Othello board RAM once per start request and tallies cell
// classes, producing piece/empty/border counts, the winner and a border check.
module board_scanner #(
    parameter int CELLS      = 100,
    parameter int ADDR_W     = 7,
    parameter int RD_LAT     = 1,
    parameter int BORDER_EXP = 36
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        q,
    output logic              ctrl_mem,
    output logic              rden,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic [6:0]        black_cnt,
    output logic [6:0]        white_cnt,
    output logic [6:0]        empty_cnt,
    output logic [6:0]        border_cnt,
    output logic [1:0]        winner,
    output logic              border_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    state_t              state_q, state_d;
    logic                ctrl_mem_q, ctrl_mem_d;
    logic                rden_q, rden_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [6:0]          black_q, black_d;
    logic [6:0]          white_q, white_d;
    logic [6:0]          empty_q, empty_d;
    logic [6:0]          border_q, border_d;
    logic [1:0]          winner_q, winner_d;
    logic                border_err_q, border_err_d;
    logic [RD_LAT-1:0]   valid_q, valid_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ctrl_mem_q   <= 1'b0;
            rden_q       <= 1'b0;
            addr_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            black_q      <= '0;
            white_q      <= '0;
            empty_q      <= '0;
            border_q     <= '0;
            winner_q     <= '0;
            border_err_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            ctrl_mem_q   <= ctrl_mem_d;
            rden_q       <= rden_d;
            addr_q       <= addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            black_q      <= black_d;
            white_q      <= white_d;
            empty_q      <= empty_d;
            border_q     <= border_d;
            winner_q     <= winner_d;
            border_err_q <= border_err_d;
            valid_q      <= valid_d;
        end
    end

    // The valid pipe mirrors the RAM latency so its tail marks the cycle q belongs to a read.
    always_comb begin
        valid_d[0] = rden_q;
        for (int i = 1; i < RD_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
        end
    end

    always_comb begin
        state_d      = state_q;
        ctrl_mem_d   = ctrl_mem_q;
        rden_d       = rden_q;
        addr_d       = addr_q;
        busy_d       = busy_q;
        done_d       = done_q;
        black_d      = black_q;
        white_d      = white_q;
        empty_d      = empty_q;
        border_d     = border_q;
        winner_d     = winner_q;
        border_err_d = border_err_q;

        if (valid_q[RD_LAT-1]) begin
            case (q)
                2'b00:   empty_d  = empty_q + 7'd1;
                2'b01:   black_d  = black_q + 7'd1;
                2'b10:   white_d  = white_q + 7'd1;
                default: border_d = border_q + 7'd1;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_READ;
                    black_d      = '0;
                    white_d      = '0;
                    empty_d      = '0;
                    border_d     = '0;
                    winner_d     = '0;
                    border_err_d = 1'b0;
                    addr_d       = '0;
                    rden_d       = 1'b1;
                    ctrl_mem_d   = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            ST_READ: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    rden_d  = 1'b0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                // Counts are final once no returned data remains in flight.
                if (valid_q == '0) begin
                    state_d      = ST_DONE;
                    ctrl_mem_d   = 1'b0;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    border_err_d = (border_q != 7'(BORDER_EXP));
                    if (black_q > white_q) begin
                        winner_d = 2'b01;
                    end else if (white_q > black_q) begin
                        winner_d = 2'b10;
                    end else begin
                        winner_d = 2'b00;
                    end
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ctrl_mem   = ctrl_mem_q;
    assign rden       = rden_q;
    assign addr       = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign black_cnt  = black_q;
    assign white_cnt  = white_q;
    assign empty_cnt  = empty_q;
    assign border_cnt = border_q;
    assign winner     = winner_q;
    assign border_err = border_err_q;

endmodule

// File: tb/tb_board_scanner.sv
// Directed bench for board_scanner: one instance at read latency 1, one at 2,
// both fed from a shared board image through their own RAM read pipelines.
module tb_board_scanner;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] q1, q2, q2a;
    logic [1:0] mem [0:99];

    logic       ctrl1, rden1, busy1, done1, err1;
    logic [6:0] addr1, black1, white1, empty1, border1;
    logic [1:0] win1;
    logic       ctrl2, rden2, busy2, done2, err2;
    logic [6:0] addr2, black2, white2, empty2, border2;
    logic [1:0] win2;

    int checkCount = 0;
    int errorCount = 0;
    int lat1, lat2;

    logic monClear = 1'b0;
    int   rdCount1 = 0;
    int   rdCount2 = 0;
    logic addrBad1 = 1'b0;
    logic addrBad2 = 1'b0;

    board_scanner dut1 (
        .clock(clock), .reset(reset), .start(start), .q(q1),
        .ctrl_mem(ctrl1), .rden(rden1), .addr(addr1), .busy(busy1), .done(done1),
        .black_cnt(black1), .white_cnt(white1), .empty_cnt(empty1),
        .border_cnt(border1), .winner(win1), .border_err(err1)
    );

    board_scanner #(.RD_LAT(2)) dut2 (
        .clock(clock), .reset(reset), .start(start), .q(q2),
        .ctrl_mem(ctrl2), .rden(rden2), .addr(addr2), .busy(busy2), .done(done2),
        .black_cnt(black2), .white_cnt(white2), .empty_cnt(empty2),
        .border_cnt(border2), .winner(win2), .border_err(err2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        q1  <= mem[addr1];
        q2a <= mem[addr2];
        q2  <= q2a;
    end

    // Every issued read must carry the next address of a single contiguous sweep.
    always @(negedge clock) begin
        if (monClear) begin
            rdCount1 = 0;
            rdCount2 = 0;
            addrBad1 = 1'b0;
            addrBad2 = 1'b0;
        end else begin
            if (rden1) begin
                if (addr1 != 7'(rdCount1)) addrBad1 = 1'b1;
                rdCount1++;
            end
            if (rden2) begin
                if (addr2 != 7'(rdCount2)) addrBad2 = 1'b1;
                rdCount2++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic loadInitial();
        for (int i = 0; i < 100; i++) begin
            if (i / 10 == 0 || i / 10 == 9 || i % 10 == 0 || i % 10 == 9) mem[i] = 2'b11;
            else mem[i] = 2'b00;
        end
        mem[44] = 2'b01;
        mem[55] = 2'b01;
        mem[45] = 2'b10;
        mem[54] = 2'b10;
    endtask

    task automatic clearMonitor();
        monClear = 1'b1;
        @(negedge clock);
        @(posedge clock);
        #1;
        monClear = 1'b0;
    endtask

    task automatic applyStimulus(input bit holdStart, output int l1, output int l2);
        clearMonitor();
        start = 1'b1;
        @(posedge clock);
        #1;
        if (!holdStart) start = 1'b0;
        l1 = 0;
        l2 = 0;
        for (int n = 1; n <= 300 && (l1 == 0 || l2 == 0); n++) begin
            @(posedge clock);
            #1;
            if (n == 50) begin
                checkOutput("busyMid", {31'd0, busy1}, 32'd1);
                checkOutput("ctrlMid", {31'd0, ctrl1}, 32'd1);
            end
            if (done1 && l1 == 0) l1 = n;
            if (done2 && l2 == 0) l2 = n;
        end
    endtask

    task automatic checkCounts(input string tag, input int b, input int w, input int e,
                               input int bd, input int win, input int err);
        checkOutput({tag, ".black"},  {25'd0, black1},  b);
        checkOutput({tag, ".white"},  {25'd0, white1},  w);
        checkOutput({tag, ".empty"},  {25'd0, empty1},  e);
        checkOutput({tag, ".border"}, {25'd0, border1}, bd);
        checkOutput({tag, ".winner"}, {30'd0, win1},    win);
        checkOutput({tag, ".err"},    {31'd0, err1},    err);
        checkOutput({tag, ".addrSeq"}, {31'd0, addrBad1}, 0);
        checkOutput({tag, ".reads"},  rdCount1, 100);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".ctrl"},   {31'd0, ctrl1},   0);
        checkOutput({tag, ".rden"},   {31'd0, rden1},   0);
        checkOutput({tag, ".addr"},   {25'd0, addr1},   0);
        checkOutput({tag, ".busy"},   {31'd0, busy1},   0);
        checkOutput({tag, ".done"},   {31'd0, done1},   0);
        checkOutput({tag, ".black"},  {25'd0, black1},  0);
        checkOutput({tag, ".white"},  {25'd0, white1},  0);
        checkOutput({tag, ".empty"},  {25'd0, empty1},  0);
        checkOutput({tag, ".border"}, {25'd0, border1}, 0);
        checkOutput({tag, ".winner"}, {30'd0, win1},    0);
        checkOutput({tag, ".err"},    {31'd0, err1},    0);
        checkOutput({tag, ".ctrl2"},  {31'd0, ctrl2},   0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
        end
        #1;
    endtask

    initial begin
        loadInitial();
        reset = 1'b1;
        idleCycles(3);
        checkReset("reset");
        reset = 1'b0;
        idleCycles(2);

        applyStimulus(1'b0, lat1, lat2);
        checkOutput("init.lat1", lat1, 102);
        checkOutput("init.lat2", lat2, 103);
        checkCounts("init", 2, 2, 60, 36, 0, 0);
        checkOutput("init.ctrlAfter", {31'd0, ctrl1}, 0);
        checkOutput("lat2.black",  {25'd0, black2},  2);
        checkOutput("lat2.white",  {25'd0, white2},  2);
        checkOutput("lat2.empty",  {25'd0, empty2},  60);
        checkOutput("lat2.border", {25'd0, border2}, 36);
        checkOutput("lat2.err",    {31'd0, err2},    0);
        checkOutput("lat2.addrSeq", {31'd0, addrBad2}, 0);
        checkOutput("lat2.reads",  rdCount2, 100);
        idleCycles(3);

        for (int i = 0; i < 100; i++) begin
            if (mem[i] != 2'b11) mem[i] = 2'b01;
        end
        mem[11] = 2'b10;
        applyStimulus(1'b0, lat1, lat2);
        checkCounts("interior", 63, 1, 0, 36, 1, 0);
        idleCycles(3);

        loadInitial();
        mem[0] = 2'b00;
        applyStimulus(1'b0, lat1, lat2);
        checkCounts("corrupt", 2, 2, 61, 35, 0, 1);
        idleCycles(3);

        loadInitial();
        applyStimulus(1'b1, lat1, lat2);
        idleCycles(20);
        checkOutput("hold.done", {31'd0, done1}, 1);
        checkOutput("hold.ctrl", {31'd0, ctrl1}, 0);
        checkOutput("hold.rden", {31'd0, rden1}, 0);
        checkCounts("hold", 2, 2, 60, 36, 0, 0);
        start = 1'b0;
        idleCycles(1);
        checkOutput("hold.doneDrop", {31'd0, done1}, 0);
        checkOutput("hold.blackKept", {25'd0, black1}, 2);
        checkOutput("hold.borderKept", {25'd0, border1}, 36);
        idleCycles(3);

        clearMonitor();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        lat1 = 0;
        for (int n = 0; n < 200 && lat1 == 0; n++) begin
            @(negedge clock);
            if (addr1 == 7'd50) lat1 = 1;
        end
        checkOutput("abort.reached50", lat1, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkReset("abort");
        reset = 1'b0;
        idleCycles(3);
        applyStimulus(1'b0, lat1, lat2);
        checkOutput("fresh.lat1", lat1, 102);
        checkCounts("fresh", 2, 2, 60, 36, 0, 0);
        idleCycles(3);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/board_scanner.md
Name: board_scanner

Overview:
- Reads the 10x10 Othello board memory (100 cells, 2-bit codes) after it has been written.
- Sweeps addresses 0..99, classifies every cell, and reports piece counts, empty count, border count, winner and a border-integrity error.
- Sits on the shared board RAM port: it takes the port via ctrl_mem while scanning, then releases it.
- Used for the score display and end-of-game decision.

Parameters:
- CELLS, 100, number of addresses swept (0..CELLS-1).
- ADDR_W, 7, address width.
- RD_LAT, 1, RAM read latency in cycles from addr/rden to valid q; legal values 1 or 2.
- BORDER_EXP, 36, expected number of border (11) cells.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level request; sampled only in IDLE.
- q  input  2  RAM read data: 00 empty, 01 black, 10 white, 11 border.
- ctrl_mem  output  1  1 = scanner owns the RAM port.
- rden  output  1  read strobe.
- addr  output  ADDR_W  read address.
- busy  output  1  high in READ and DRAIN.
- done  output  1  high in DONE.
- black_cnt  output  7  count of 01 cells.
- white_cnt  output  7  count of 10 cells.
- empty_cnt  output  7  count of 00 cells.
- border_cnt  output  7  count of 11 cells.
- winner  output  2  01 black ahead, 10 white ahead, 00 tie; valid when done=1.
- border_err  output  1  border_cnt != BORDER_EXP; valid when done=1.

Behaviour:
- All outputs are registered.
- Reset (reset=1 at an edge): state IDLE; every output 0; valid pipeline cleared.
- Reset mid-scan aborts immediately with the same reset values. There is no partial result.

State machine:
- IDLE:
  - ctrl_mem=0, rden=0.
  - start=1 → READ. On the same edge, clear all four counters, winner and border_err; set addr=0, rden=1, ctrl_mem=1.
- READ:
  - One read issued per cycle: addr increments by 1 each cycle while rden=1.
  - At the edge where addr=CELLS-1 has been presented → DRAIN. On that edge rden=0; addr holds CELLS-1; ctrl_mem stays 1.
- DRAIN:
  - Waits until the returned-data pipeline is empty (RD_LAT cycles after the last read).
  - → DONE. On that edge ctrl_mem=0; winner and border_err are computed from the final counts.
- DONE:
  - done=1; counts and winner held.
  - start=0 → IDLE, with done=0 on that edge and counts still held.
  - A level-high start never retriggers a second scan.

Data capture:
- A valid shift register of depth RD_LAT tracks rden. When its tail is 1, q is classified and exactly one counter increments by 1.
- Counters never exceed CELLS (100), so 7 bits never wrap; no saturation logic is needed.

Invariants and timing:
- At DONE: black_cnt+white_cnt+empty_cnt+border_cnt = CELLS.
- Latency: done rises exactly CELLS+RD_LAT+1 edges after the edge that samples start=1 in IDLE. For defaults this is 102.

Output rules:
- winner: black_cnt>white_cnt → 01; white_cnt>black_cnt → 10; equal → 00.
- start during READ/DRAIN/DONE is ignored, apart from the DONE exit rule above.
- ctrl_mem is 1 exactly from the first read through the last data return; it is never 1 in IDLE or DONE.

Test Plan:
- Initial board (border ring =11, addr 44 and 55 =01, 45 and 54 =10, rest 00), start pulse → done at edge 102; black_cnt=2, white_cnt=2, empty_cnt=60, border_cnt=36, winner=00, border_err=0.
- Interior all 01 except addr 11 =10 → black_cnt=63, white_cnt=1, empty_cnt=0, winner=01, border_err=0.
- Corrupt addr 0 to 00 on the initial board → border_cnt=35, empty_cnt=61, border_err=1.
- start held high through DONE for 20 cycles → exactly one sweep (rden high 100 cycles total); done stays 1 until start drops, then IDLE and done=0; counts held.
- reset=1 when addr=50 → next edge: all outputs 0, ctrl_mem=0. A fresh start then gives the full correct counts.
- RD_LAT=2 with the initial board → identical counts; done at edge 103; addr sequence 0..99 contiguous with no gaps or repeats.
